// File: rtl/huffman_pkg.sv
`default_nettype none
// ============================================================================
// Module   : huffman_pkg
// Brief    : Shared constants, FSM states and mask helpers for huffman_dec.
// Revision : 1.0 - initial release
// ============================================================================
package huffman_pkg;

    localparam int NSYM   = 6;
    localparam int CODE_W = 8;

    typedef enum logic [1:0] {
        NOTAB   = 2'd0,
        READY   = 2'd1,
        PARTIAL = 2'd2
    } state_t;

    // A legal mask is a contiguous run of ones from bit 0, i.e. 2^L-1 with L>=1.
    function automatic logic mask_legal(input logic [CODE_W-1:0] m);
        logic [CODE_W-1:0] m_inc;
        m_inc = m + 1'b1;
        return (m != '0) && ((m & m_inc) == '0);
    endfunction

    function automatic logic [3:0] mask_len(input logic [CODE_W-1:0] m);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < CODE_W; i++) begin
            n = n + {3'd0, m[i]};
        end
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/huffman_dec_if.sv
`default_nettype none
// ============================================================================
// Module   : huffman_dec_if
// Brief    : Table-load, bit-stream and decoded-symbol signals of huffman_dec.
// Revision : 1.0 - initial release
// ============================================================================
interface huffman_dec_if;
    import huffman_pkg::*;

    logic              code_valid;
    logic [CODE_W-1:0] HC1, HC2, HC3, HC4, HC5, HC6;
    logic [CODE_W-1:0] M1, M2, M3, M4, M5, M6;
    logic              bit_valid;
    logic              bit_in;
    logic              table_ok;
    logic              sym_valid;
    logic [7:0]        sym_data;
    logic              err;
    logic [15:0]       sym_cnt;

    modport master (
        output code_valid, HC1, HC2, HC3, HC4, HC5, HC6,
               M1, M2, M3, M4, M5, M6, bit_valid, bit_in,
        input  table_ok, sym_valid, sym_data, err, sym_cnt
    );

    modport slave (
        input  code_valid, HC1, HC2, HC3, HC4, HC5, HC6,
               M1, M2, M3, M4, M5, M6, bit_valid, bit_in,
        output table_ok, sym_valid, sym_data, err, sym_cnt
    );

endinterface
`default_nettype wire

// File: rtl/huffman_match.sv
`default_nettype none
// ============================================================================
// Module   : huffman_match
// Brief    : Combinational codeword lookup; reports the lowest matching entry.
// Revision : 1.0 - initial release
// ============================================================================
module huffman_match
    import huffman_pkg::*;
(
    input  logic [NSYM-1:0][CODE_W-1:0] hc,
    input  logic [NSYM-1:0][CODE_W-1:0] m,
    input  logic [CODE_W-1:0]           acc_n,
    input  logic [3:0]                  len_n,
    output logic                        hit,
    output logic [2:0]                  idx
);

    logic [CODE_W:0]   w_pow;
    logic [CODE_W-1:0] w_want;

    assign w_pow  = (CODE_W+1)'(1) << len_n;
    assign w_want = CODE_W'(w_pow - 1'b1);

    // Scan from the top so the lowest matching index is the one left standing.
    always_comb begin
        hit = 1'b0;
        idx = 3'd0;
        for (int i = NSYM - 1; i >= 0; i--) begin
            if ((m[i] == w_want) && ((hc[i] & m[i]) == acc_n)) begin
                hit = 1'b1;
                idx = 3'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/huffman_dec.sv
`default_nettype none
// ============================================================================
// Module   : huffman_dec
// Brief    : Serial 6-symbol Huffman decoder with table load and error flags.
// Revision : 1.0 - initial release
// ============================================================================
module huffman_dec
    import huffman_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    huffman_dec_if.slave  bus
);

    state_t r_state, w_state_nxt;

    logic [NSYM-1:0][CODE_W-1:0] r_hc, r_m, w_hc_in, w_m_in;
    logic [CODE_W-1:0] r_acc, w_acc_nxt, w_acc_n;
    logic [3:0]        r_len, w_len_nxt, w_len_n;
    logic              r_table_ok, w_table_ok_nxt;
    logic              r_sym_valid, w_sym_valid_nxt;
    logic [7:0]        r_sym_data, w_sym_data_nxt;
    logic              r_err, w_err_nxt;
    logic [15:0]       r_sym_cnt, w_sym_cnt_nxt;
    logic              w_legal;
    logic              w_hit;
    logic [2:0]        w_idx;

    assign w_hc_in = {bus.HC6, bus.HC5, bus.HC4, bus.HC3, bus.HC2, bus.HC1};
    assign w_m_in  = {bus.M6,  bus.M5,  bus.M4,  bus.M3,  bus.M2,  bus.M1};
    assign w_acc_n = {r_acc[CODE_W-2:0], bus.bit_in};
    assign w_len_n = r_len + 4'd1;

    always_comb begin
        w_legal = 1'b1;
        for (int i = 0; i < NSYM; i++) begin
            w_legal = w_legal & mask_legal(w_m_in[i]);
        end
    end

    huffman_match u_match (
        .hc    (r_hc),
        .m     (r_m),
        .acc_n (w_acc_n),
        .len_n (w_len_n),
        .hit   (w_hit),
        .idx   (w_idx)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= NOTAB;
            r_hc        <= '0;
            r_m         <= '0;
            r_acc       <= '0;
            r_len       <= '0;
            r_table_ok  <= 1'b0;
            r_sym_valid <= 1'b0;
            r_sym_data  <= '0;
            r_err       <= 1'b0;
            r_sym_cnt   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_acc       <= w_acc_nxt;
            r_len       <= w_len_nxt;
            r_table_ok  <= w_table_ok_nxt;
            r_sym_valid <= w_sym_valid_nxt;
            r_sym_data  <= w_sym_data_nxt;
            r_err       <= w_err_nxt;
            r_sym_cnt   <= w_sym_cnt_nxt;
            if (bus.code_valid) begin
                r_hc <= w_hc_in;
                r_m  <= w_m_in;
            end
        end
    end

    // A table load takes priority over any bit presented in the same cycle.
    always_comb begin
        w_state_nxt     = r_state;
        w_acc_nxt       = r_acc;
        w_len_nxt       = r_len;
        w_table_ok_nxt  = r_table_ok;
        w_sym_valid_nxt = 1'b0;
        w_sym_data_nxt  = r_sym_data;
        w_err_nxt       = 1'b0;
        w_sym_cnt_nxt   = r_sym_cnt;

        if (bus.code_valid) begin
            w_acc_nxt     = '0;
            w_len_nxt     = '0;
            w_sym_cnt_nxt = '0;
            if (w_legal) begin
                w_table_ok_nxt = 1'b1;
                w_state_nxt    = READY;
            end else begin
                w_table_ok_nxt = 1'b0;
                w_err_nxt      = 1'b1;
                w_state_nxt    = NOTAB;
            end
        end else if (bus.bit_valid && (r_state != NOTAB)) begin
            if (w_hit) begin
                w_sym_valid_nxt = 1'b1;
                w_sym_data_nxt  = 8'(w_idx) + 8'd1;
                w_sym_cnt_nxt   = r_sym_cnt + 16'd1;
                w_acc_nxt       = '0;
                w_len_nxt       = '0;
                w_state_nxt     = READY;
            end else if (w_len_n < 4'(CODE_W)) begin
                w_acc_nxt   = w_acc_n;
                w_len_nxt   = w_len_n;
                w_state_nxt = PARTIAL;
            end else begin
                w_err_nxt   = 1'b1;
                w_acc_nxt   = '0;
                w_len_nxt   = '0;
                w_state_nxt = READY;
            end
        end
    end

    assign bus.table_ok  = r_table_ok;
    assign bus.sym_valid = r_sym_valid;
    assign bus.sym_data  = r_sym_data;
    assign bus.err       = r_err;
    assign bus.sym_cnt   = r_sym_cnt;

endmodule
`default_nettype wire
